shift_sched: RTL and testbench
==============================

# shift_sched

Multi-cycle shift sequencer shared by two requesters in the RV32I core. It grants one request at a time (round-robin), then performs the SLL/SRL/SRA over several cycles, shifting STEP bits per cycle instead of using a full 32-bit barrel shifter. It returns the result on a valid/ready response port tagged with the winning requester. It sits beside the ALU for area-reduced builds; the ALU and the load-alignment path are the two requesters.

## Interface
- STEP, 4, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8, 16.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_rs1 / req1_rs1  in  32  operand to shift.
- req0_shamt / req1_shamt  in  5  shift amount.
- req0_op / req1_op  in  2  shift operation:
  - 00 SLL
  - 01 SRL
  - 11 SRA
  - 10 reserved, executes as SRL.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester index of the result.
- rsp_data  out  32  shifted result.
- busy  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, SHIFT, RESP.
- **IDLE**
  - Arbitrate among valid requesters and assert ready for the winner only, combinationally from valid, same cycle.
  - On handshake, latch rs1 into the work register, plus shamt into the remaining counter (5 bits), op and id.
  - Requester inputs are don't-care after acceptance.
  - Next state is SHIFT if shamt≠0, else RESP.
- **SHIFT**, each cycle:
  - Shift amount k = STEP if remaining ≥ STEP, else remaining.
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the latched operand's bit 31.
  - Decrement remaining by k; when it reaches 0, go to RESP.
- **RESP**
  - rsp_valid=1; rsp_data and rsp_id are stable while rsp_valid is high and rsp_ready is low.
  - On rsp_valid&rsp_ready, return to IDLE.
  - No new request is accepted in the RESP cycle.
- Arbitration:
  - A round-robin pointer favors the requester that did not win the last grant; the pointer updates only on an accepted request.
  - A single valid requester always wins.
- Both readies are 0 outside IDLE.
- The result must equal the RV32I reference: rs1<<shamt, rs1>>shamt, or $signed(rs1)>>>shamt.

## Timing
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req0_ready=req1_ready=0 unless the corresponding valid is high.
  - RR pointer favors req0.
- Accept at edge T:
  - rsp_valid rises after edge T+1+ceil(shamt/STEP).
  - Latency 1 cycle for shamt=0; 9 cycles for shamt=31 with STEP=4.
- Earliest next accept is the cycle after the response handshake (IDLE cycle).
- Reset mid-SHIFT or mid-RESP: immediate return to IDLE. The in-flight result is discarded, with no rsp_valid pulse.
- Both requesters valid in the same IDLE cycle: exactly one ready is high.

## Configuration
- SHIFT_SCHED_RR_EN
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, req0 always wins when valid; the pointer register is removed.

## Test plan
- Assert reset mid-operation (SRA 0x8000_0000 shamt=31 in SHIFT), release -> rsp_valid=0, busy=0, IDLE; no stale response appears afterward.
- STEP=4, req0 SRA rs1=0x8000_0000 shamt=4 -> rsp_valid at T+2, rsp_data=0xF800_0000, rsp_id=0.
- req1 SRL rs1=0x8000_0000 shamt=31 -> rsp_valid at T+9, rsp_data=0x0000_0001, rsp_id=1; same operand with SRA -> 0xFFFF_FFFF.
- req0 SLL rs1=0x1234_5678 shamt=0 -> rsp_valid at T+1, data 0x1234_5678; op=10 with shamt=8 on 0x8000_00FF -> 0x0080_0000.
- Both valid continuously, rsp_ready=1:
  - With SHIFT_SCHED_RR_EN: rsp_id sequence 0,1,0,1.
  - Without: rsp_id sequence 0,0,0,0.
- Hold rsp_ready=0 for 5 cycles after SLL 0x0000_0001 shamt=9 -> rsp_data=0x0000_0200 stable, readies 0, busy 1; releases one cycle after rsp_ready=1.

Source files
------------

// File: rtl/shift_sched.sv
// shift_sched: round-robin shared multi-cycle SLL/SRL/SRA sequencer, STEP bits per cycle.
// Build option SHIFT_SCHED_RR_EN: defined = round-robin grant, undefined = fixed priority to req0.
`default_nettype none

module shift_sched #(
  parameter int STEP = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_rs1,
  input  logic [4:0]  req0_shamt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_rs1,
  input  logic [4:0]  req1_shamt,
  input  logic [1:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [4:0] STEP_AMT = 5'(STEP);

  logic [1:0]  state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  rem_q, rem_d;
  logic [1:0]  op_q, op_d;
  logic        id_q, id_d;
  logic        sign_q, sign_d;

  logic        w_idle;
  logic        w_grant0, w_grant1;
  logic [4:0]  w_k;
  logic [31:0] w_fill;
  logic [31:0] w_shifted;

  assign w_idle = (state_q == ST_IDLE);

`ifdef SHIFT_SCHED_RR_EN
  // rr_q=0 favours req0, rr_q=1 favours req1.
  logic rr_q, rr_d;
  assign w_grant0 = req0_valid & (~req1_valid | ~rr_q);
  assign w_grant1 = req1_valid & (~req0_valid | rr_q);

  always_comb begin
    rr_d = rr_q;
    if (w_idle && (w_grant0 || w_grant1)) rr_d = w_grant0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_q <= 1'b0;
    else          rr_q <= rr_d;
  end
`else
  assign w_grant0 = req0_valid;
  assign w_grant1 = req1_valid & ~req0_valid;
`endif

  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;

  // Last partial step shifts by whatever remains below STEP.
  assign w_k    = (rem_q >= STEP_AMT) ? STEP_AMT : rem_q;
  assign w_fill = ~(32'hFFFF_FFFF >> w_k);

  always_comb begin
    case (op_q)
      2'b00:   w_shifted = work_q << w_k;
      2'b11:   w_shifted = (work_q >> w_k) | (sign_q ? w_fill : 32'h0);
      default: w_shifted = work_q >> w_k;
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    id_d    = id_q;
    sign_d  = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (w_grant0 || w_grant1) begin
          work_d  = w_grant1 ? req1_rs1   : req0_rs1;
          rem_d   = w_grant1 ? req1_shamt : req0_shamt;
          op_d    = w_grant1 ? req1_op    : req0_op;
          id_d    = w_grant1;
          sign_d  = w_grant1 ? req1_rs1[31] : req0_rs1[31];
          state_d = ((w_grant1 ? req1_shamt : req0_shamt) != 5'd0) ? ST_SHIFT : ST_RESP;
        end
      end
      ST_SHIFT: begin
        work_d = w_shifted;
        rem_d  = rem_q - w_k;
        if (rem_q == w_k) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= 32'h0;
      rem_q   <= 5'd0;
      op_q    <= 2'b00;
      id_q    <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      id_q    <= id_d;
      sign_q  <= sign_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = work_q;
  assign busy      = ~w_idle;

endmodule

`default_nettype wire

// File: tb/tb_shift_sched.sv
// tb_shift_sched: randomized scoreboard bench for shift_sched against an RV32I shift reference.
`default_nettype none

module tb_shift_sched;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  v = 2'b00;
  logic [31:0] rs1 [2];
  logic [4:0]  sh [2];
  logic [1:0]  op [2];
  logic        rdy0, rdy1;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  shift_sched #(.STEP(STEP)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .req0_valid(v[0]), .req0_ready(rdy0), .req0_rs1(rs1[0]), .req0_shamt(sh[0]), .req0_op(op[0]),
    .req1_valid(v[1]), .req1_ready(rdy1), .req1_rs1(rs1[1]), .req1_shamt(sh[1]), .req1_op(op[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  typedef struct { logic id; logic [31:0] data; int due; } exp_t;
  exp_t exp_q[$];
  int   id_log[$];
  int   checks = 0, errors = 0, cyc = 0;
  bit   outstanding = 0;
  int   last = 1;
  bit   accepted [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s, input logic [1:0] o);
    case (o)
      2'b00:   return a << s;
      2'b11:   return $signed(a) >>> s;
      default: return a >> s;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / reference model, sampled on the falling edge.
  always @(negedge clk) begin : mon
    logic [1:0] r, e;
    exp_t x;
    if (rst_n) begin
      r = {rdy1, rdy0};
      if (outstanding) begin
        x = exp_q[0];
        chk("ready_while_busy", {30'd0, r}, 0);
        chk("busy_active", busy, 1);
        chk("rsp_valid_timing", rsp_valid, cyc >= x.due);
        if (rsp_valid) begin
          chk("rsp_id", rsp_id, x.id);
          chk("rsp_data", rsp_data, x.data);
          if (rsp_ready) begin
            id_log.push_back(int'(x.id));
            x = exp_q.pop_front();
            outstanding = 0;
          end
        end
      end else begin
`ifdef SHIFT_SCHED_RR_EN
        e[0] = v[0] && (!v[1] || last == 1);
        e[1] = v[1] && (!v[0] || last == 0);
`else
        e[0] = v[0];
        e[1] = v[1] && !v[0];
`endif
        chk("arb_ready", {30'd0, r}, {30'd0, e});
        chk("busy_idle", busy, 0);
        chk("rsp_valid_idle", rsp_valid, 0);
        for (int i = 0; i < 2; i++) begin
          if (v[i] && r[i]) begin
            x.id   = 1'(i);
            x.data = ref_shift(rs1[i], sh[i], op[i]);
            x.due  = cyc + 1 + (int'(sh[i]) + STEP - 1) / STEP;
            exp_q.push_back(x);
            outstanding = 1;
            last = i;
            accepted[i] = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [31:0] a, input logic [4:0] s, input logic [1:0] o);
    int n = 0;
    rs1[i] = a; sh[i] = s; op[i] = o;
    accepted[i] = 0;
    v[i] = 1'b1;
    while (!accepted[i] && n < 20) begin tick(); n++; end
    if (!accepted[i]) chk("accept_timeout", 0, 1);
    v[i] = 1'b0;
    accepted[i] = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (outstanding && n < 100) begin tick(); n++; end
    if (outstanding) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin rs1[i] = 0; sh[i] = 0; op[i] = 0; accepted[i] = 0; end
    rsp_ready = 1'b1;
    repeat (3) tick();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    v[0] = 1'b1;
    #1 chk("reset_ready_follows_valid", {30'd0, rdy1, rdy0}, 1);
    v[0] = 1'b0;
    #1 rst_n = 1'b1;
    tick();

    send(0, 32'h8000_0000, 4, 2'b11);  wait_idle();
    send(1, 32'h8000_0000, 31, 2'b01); wait_idle();
    send(1, 32'h8000_0000, 31, 2'b11); wait_idle();
    send(0, 32'h1234_5678, 0, 2'b00);  wait_idle();
    send(0, 32'h8000_00FF, 8, 2'b10);  wait_idle();

    // Reset while the shift is in flight: the result must never surface.
    send(0, 32'h8000_0000, 31, 2'b11);
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_busy", busy, 0);
    exp_q.delete();
    outstanding = 0;
    last = 1;
    repeat (2) tick();
    #2 rst_n = 1'b1;
    repeat (12) tick();

    // Both requesters valid continuously.
    id_log.delete();
    rs1[0] = $urandom; sh[0] = 5'd2; op[0] = 2'b00;
    rs1[1] = $urandom; sh[1] = 5'd3; op[1] = 2'b11;
    v = 2'b11;
    n = 0;
    while (id_log.size() < 4 && n < 100) begin tick(); n++; end
    v = 2'b00;
    accepted[0] = 0; accepted[1] = 0;
    wait_idle();
    chk("arb_seq_len", (id_log.size() >= 4), 1);
    for (int k = 0; k < 4 && k < id_log.size(); k++) begin
`ifdef SHIFT_SCHED_RR_EN
      chk("arb_seq", id_log[k], k % 2);
`else
      chk("arb_seq", id_log[k], 0);
`endif
    end

    // Response back-pressure with a pending competing request.
    rsp_ready = 1'b0;
    send(0, 32'h0000_0001, 9, 2'b00);
    rs1[1] = 32'hF0F0_1234; sh[1] = 5'd5; op[1] = 2'b01;
    v[1] = 1'b1;
    n = 0;
    while (!rsp_valid && n < 30) begin tick(); n++; end
    repeat (5) tick();
    chk("stall_data", rsp_data, 32'h0000_0200);
    chk("stall_busy", busy, 1);
    rsp_ready = 1'b1;
    n = 0;
    while (!accepted[1] && n < 20) begin tick(); n++; end
    if (!accepted[1]) chk("stall_followup_timeout", 0, 1);
    v[1] = 1'b0;
    accepted[1] = 0;
    wait_idle();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (accepted[i]) begin accepted[i] = 0; v[i] = 1'b0; end
        if (!v[i] && $urandom_range(2) == 0) begin
          rs1[i] = $urandom;
          sh[i]  = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 5'd0 : 5'd31) : 5'($urandom_range(31));
          op[i]  = 2'($urandom_range(3));
          v[i]   = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
    end
    v = 2'b00;
    rsp_ready = 1'b1;
    tick();
    wait_idle();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
